// File: rtl/boolean_expression_pkg.sv
// ----------------------------------------------------------------------------
// boolean_expression_pkg
//   Shared constants and helpers for the boolean_expression leaf cell.
//   - TT_* : 4-entry truth tables indexed by {a,b} (bit0 = a0b0, bit3 = a1b1)
//   - idx  : forms the truth-table index {a,b}
// ----------------------------------------------------------------------------
package boolean_expression_pkg;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic logic [1:0] idx(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/boolexpr_sat_cnt.sv
// ----------------------------------------------------------------------------
// boolexpr_sat_cnt
//   Generic saturating up-counter. Increments on i_inc and holds at all-ones.
//   Ports:
//     clk     in  1   rising-edge clock
//     rst_n   in  1   asynchronous active-low reset (count -> 0)
//     i_inc   in  1   increment request
//     o_count out W   current count
//     o_sat   out 1   high while o_count is all-ones (combinational)
// ----------------------------------------------------------------------------
module boolexpr_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_sat
);

    logic [W-1:0] r_count;
    logic         w_sat;

    assign w_sat = (r_count == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_sat   = w_sat;

endmodule

// File: rtl/boolean_expression.sv
// ----------------------------------------------------------------------------
// boolean_expression
//   Two-input Boolean function generator: y = TRUTH_TABLE[{a,b}] (default XOR).
//   Side path: registered y, one-hot minterm decode, and an optional saturating
//   count of y_q rising edges.
//   Build option: define BOOLEXPR_STATS_EN to build the rise counter; otherwise
//   y_rise_cnt and cnt_sat are tied to 0 and no counter flops exist.
//   Ports:
//     a, b        in  1      operands ({a,b} is the table index, a = MSB)
//     y           out 1      combinational result
//     clk         in  1      rising-edge clock
//     rst_n       in  1      asynchronous active-low reset
//     y_q         out 1      y registered on clk
//     minterm     out 4      one-hot decode of {a,b} (combinational)
//     y_rise_cnt  out CNT_W  saturating count of y_q 0->1 transitions
//     cnt_sat     out 1      high while y_rise_cnt is all-ones
// ----------------------------------------------------------------------------
module boolean_expression
    import boolean_expression_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE = TT_XOR,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             a,
    input  logic             b,
    output logic             y,
    input  logic             clk,
    input  logic             rst_n,
    output logic             y_q,
    output logic [3:0]       minterm,
    output logic [CNT_W-1:0] y_rise_cnt,
    output logic             cnt_sat
);

    logic [1:0] w_idx;
    logic       w_y;
    logic       r_y_q;

    assign w_idx = idx(a, b);
    // Variable index keeps X/Z on a or b visible on y in 4-state simulation.
    assign w_y   = TRUTH_TABLE[w_idx];
    assign y     = w_y;

    always_comb begin
        minterm = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            minterm[k] = (w_idx == k[1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q <= 1'b0;
        end else begin
            r_y_q <= w_y;
        end
    end

    assign y_q = r_y_q;

`ifdef BOOLEXPR_STATS_EN
    logic w_rise;

    // Rise seen at the edge where y_q is about to go 0 -> 1.
    assign w_rise = ~r_y_q & w_y;

    boolexpr_sat_cnt #(
        .W (CNT_W)
    ) u_sat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rise),
        .o_count (y_rise_cnt),
        .o_sat   (cnt_sat)
    );
`else
    assign y_rise_cnt = '0;
    assign cnt_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_boolean_expression.sv
module tb_boolean_expression;
    import boolean_expression_pkg::*;

`ifdef BOOLEXPR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;
    logic a      = 1'b0;
    logic b      = 1'b0;

    int checks = 0;
    int errors = 0;

    // Default table (XOR), CNT_W = 8
    logic       x_y, x_yq, x_sat;
    logic [3:0] x_mt;
    logic [7:0] x_cnt;
    // AND table
    logic       n_y, n_yq, n_sat;
    logic [3:0] n_mt;
    logic [7:0] n_cnt;
    // XOR, CNT_W = 2
    logic       c_y, c_yq, c_sat;
    logic [3:0] c_mt;
    logic [1:0] c_cnt;
    // Table 0000
    logic       z_y, z_yq, z_sat;
    logic [3:0] z_mt;
    logic [7:0] z_cnt;
    // Table 1111
    logic       o_y, o_yq, o_sat;
    logic [3:0] o_mt;
    logic [7:0] o_cnt;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    boolean_expression u_xor (
        .a(a), .b(b), .y(x_y), .clk(clk), .rst_n(rst_n), .y_q(x_yq),
        .minterm(x_mt), .y_rise_cnt(x_cnt), .cnt_sat(x_sat)
    );
    boolean_expression #(.TRUTH_TABLE(TT_AND)) u_and (
        .a(a), .b(b), .y(n_y), .clk(clk), .rst_n(rst_n), .y_q(n_yq),
        .minterm(n_mt), .y_rise_cnt(n_cnt), .cnt_sat(n_sat)
    );
    boolean_expression #(.CNT_W(2)) u_c2 (
        .a(a), .b(b), .y(c_y), .clk(clk), .rst_n(rst_n), .y_q(c_yq),
        .minterm(c_mt), .y_rise_cnt(c_cnt), .cnt_sat(c_sat)
    );
    boolean_expression #(.TRUTH_TABLE(4'b0000)) u_zero (
        .a(a), .b(b), .y(z_y), .clk(clk), .rst_n(rst_n), .y_q(z_yq),
        .minterm(z_mt), .y_rise_cnt(z_cnt), .cnt_sat(z_sat)
    );
    boolean_expression #(.TRUTH_TABLE(4'b1111)) u_one (
        .a(a), .b(b), .y(o_y), .clk(clk), .rst_n(rst_n), .y_q(o_yq),
        .minterm(o_mt), .y_rise_cnt(o_cnt), .cnt_sat(o_sat)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    function automatic logic es(input bit s);
        return STATS ? s : 1'b0;
    endfunction

    typedef struct {
        logic       a;
        logic       b;
        logic       y_xor;
        logic       y_and;
        logic       y_zero;
        logic       y_one;
        logic [3:0] mt;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000};

        #1 rst_n = 1'b0;

        // Combinational path with the clock idle
        for (int i = 0; i < 4; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            #10;
            chk($sformatf("y_xor[%0d]", i),  32'(x_y), 32'(vecs[i].y_xor));
            chk($sformatf("y_and[%0d]", i),  32'(n_y), 32'(vecs[i].y_and));
            chk($sformatf("y_zero[%0d]", i), 32'(z_y), 32'(vecs[i].y_zero));
            chk($sformatf("y_one[%0d]", i),  32'(o_y), 32'(vecs[i].y_one));
            chk($sformatf("minterm[%0d]", i), 32'(x_mt), 32'(vecs[i].mt));
        end

        // Reset held with clock running, then release and a 00->01 step
        a = 1'b0; b = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_yq",    32'(x_yq),  32'd0);
        chk("rst_cnt",   32'(x_cnt), 32'd0);
        chk("rst_sat",   32'(c_sat), 32'd0);
        chk("rst_one_yq", 32'(o_yq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_yq",     32'(x_yq),  32'd0);
        chk("one_yq",     32'(o_yq),  32'd1);
        chk("one_cnt1",   32'(o_cnt), ec(1));
        chk("zero_cnt0",  32'(z_cnt), 32'd0);
        a = 1'b0; b = 1'b1;
        #1;
        chk("y_pre_edge",  32'(x_y),  32'd1);
        chk("yq_pre_edge", 32'(x_yq), 32'd0);
        @(negedge clk);
        chk("yq_post_edge", 32'(x_yq),  32'd1);
        chk("cnt_first",    32'(x_cnt), ec(1));

        // Five rises on a 2-bit counter: saturate at 3, no wrap
        a = 1'b0; b = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            a = 1'b0; b = 1'b1;
            @(negedge clk);
            chk($sformatf("c2_yq_hi[%0d]", k), 32'(c_yq),  32'd1);
            chk($sformatf("c2_cnt[%0d]", k),   32'(c_cnt), ec(k > 3 ? 3 : k));
            chk($sformatf("c2_sat[%0d]", k),   32'(c_sat), 32'(es(k >= 3)));
            chk($sformatf("x_cnt[%0d]", k),    32'(x_cnt), ec(k));
            a = 1'b0; b = 1'b0;
            @(negedge clk);
            chk($sformatf("c2_yq_lo[%0d]", k), 32'(c_yq), 32'd0);
        end
        chk("x_sat_nosat", 32'(x_sat), 32'd0);
        chk("and_yq",      32'(n_yq),  32'd0);
        chk("and_cnt",     32'(n_cnt), 32'd0);
        chk("one_cnt_end", 32'(o_cnt), ec(1));
        chk("zero_cnt_end", 32'(z_cnt), 32'd0);

        // Async reset mid-cycle with the counter at 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a = 1'b0; b = 1'b1;
        @(negedge clk);
        a = 1'b0; b = 1'b0;
        @(negedge clk);
        a = 1'b0; b = 1'b1;
        @(negedge clk);
        chk("pre_rst_cnt", 32'(x_cnt), ec(2));
        chk("pre_rst_yq",  32'(x_yq),  32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_yq",  32'(x_yq),  32'd0);
        chk("async_cnt", 32'(x_cnt), 32'd0);
        chk("async_c2",  32'(c_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("resume_yq",  32'(x_yq),  32'd1);
        chk("resume_cnt", 32'(x_cnt), ec(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
